// File: rtl/ram_io_responder.sv
// Byte-wide RAM/IO responder behind the memory controller. It serves registered
// RAM reads and writes, a TX byte FIFO, RX byte pops and a program-end strobe.
module ram_io_responder #(
  parameter int ADDR_WIDTH     = 17,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_end,
  output logic        io_overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam logic [FIFO_DEPTH_LOG:0] DEPTH_C  = (FIFO_DEPTH_LOG+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG:0] MARGIN_C = (FIFO_DEPTH_LOG+1)'(DEPTH - 2);
  localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
  localparam logic [17:0] IO_END_ADDR  = 18'h30004;

  typedef enum logic [1:0] {REG_RAM, REG_HOLE, REG_IO} region_e;

  logic [7:0] ram_q  [2**ADDR_WIDTH];
  logic [7:0] fifo_q [DEPTH];

  logic [FIFO_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG:0]   count_q, count_d;
  logic [7:0]                mem_dout_q, mem_dout_d;
  logic                      buf_full_q, buf_full_d;
  logic                      rx_pop_q, rx_pop_d;
  logic                      program_end_q, program_end_d;
  logic                      overflow_q, overflow_d;

  region_e                 region;
  logic [17:0]             io_addr;
  logic [ADDR_WIDTH-1:0]   ram_idx;
  logic                    ram_we, push_req, push, pop, fifo_full;

  assign io_addr   = mem_a[17:0];
  assign ram_idx   = mem_a[ADDR_WIDTH-1:0];
  assign fifo_full = (count_q == DEPTH_C);
  assign tx_valid  = (count_q != '0);
  // The head slot is never reset, so mask it until something has been pushed.
  assign tx_data   = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;

  always_comb begin
    unique case (mem_a[17:16])
      2'b10:   region = REG_HOLE;
      2'b11:   region = REG_IO;
      default: region = REG_RAM;
    endcase
  end

  // A pop in the same cycle frees the slot the push is about to fill.
  assign ram_we   = rdy_in && mem_wr && (region == REG_RAM);
  assign push_req = rdy_in && mem_wr && (io_addr == IO_DATA_ADDR);
  assign pop      = rdy_in && tx_valid && tx_ready;
  assign push     = push_req && (!fifo_full || pop);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    mem_dout_d    = mem_dout_q;
    rx_pop_d      = 1'b0;
    program_end_d = 1'b0;
    overflow_d    = overflow_q | (push_req & ~push);
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    buf_full_d    = (count_d >= MARGIN_C);
    if (rdy_in) begin
      unique case (region)
        REG_RAM:  mem_dout_d = ram_q[ram_idx];
        REG_IO:   mem_dout_d = (!mem_wr && io_addr == IO_DATA_ADDR && rx_valid) ? rx_data : 8'h00;
        default:  mem_dout_d = 8'h00;
      endcase
      rx_pop_d      = !mem_wr && (io_addr == IO_DATA_ADDR) && rx_valid;
      program_end_d = mem_wr && (io_addr == IO_END_ADDR);
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values;
  // this is also what makes the RAM read return the old byte on a write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mem_dout_q    <= 8'h00;
      buf_full_q    <= 1'b0;
      rx_pop_q      <= 1'b0;
      program_end_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_dout_q    <= mem_dout_d;
      buf_full_q    <= buf_full_d;
      rx_pop_q      <= rx_pop_d;
      program_end_q <= program_end_d;
      overflow_q    <= overflow_d;
    end
  end

  // NOTE: storage arrays carry no reset; their contents survive rst_in and
  // stay mappable onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram_q[ram_idx] <= mem_din;
    if (push)   fifo_q[wr_ptr_q] <= mem_din;
  end

  assign mem_dout       = mem_dout_q;
  assign io_buffer_full = buf_full_q;
  assign rx_pop         = rx_pop_q;
  assign program_end    = program_end_q;
  assign io_overflow    = overflow_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: directed scenarios plus randomized
// traffic scored against a queue/associative-array reference model.
module tb_ram_io_responder;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, mem_wr, tx_ready, rx_valid;
  logic [31:0] mem_a;
  logic [7:0]  mem_din, rx_data;
  logic [7:0]  mem_dout, tx_data;
  logic        io_buffer_full, tx_valid, rx_pop, program_end, io_overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_ram [int];
  logic [7:0] m_fifo [$];
  logic [7:0] m_dout;
  logic       m_pop, m_end, m_ovf, m_bfull;

  always #5 clk = ~clk;

  ram_io_responder dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_a(mem_a), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_pop(rx_pop), .program_end(program_end), .io_overflow(io_overflow)
  );

  task automatic model_reset();
    m_fifo.delete();
    m_dout = 8'h00; m_pop = 1'b0; m_end = 1'b0; m_ovf = 1'b0; m_bfull = 1'b0;
  endtask

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a = a; mem_wr = wr; mem_din = d;
  endtask

  // One clock: model advances on the edge from pre-edge inputs; returns at negedge.
  task automatic step();
    logic [17:0] a;
    int          idx;
    @(posedge clk);
    a   = mem_a[17:0];
    idx = int'(a[16:0]);
    if (rdy_in) begin
      if (!a[17]) begin
        m_dout = m_ram.exists(idx) ? m_ram[idx] : 8'hxx;
        if (mem_wr) m_ram[idx] = mem_din;
      end else if (a == 18'h30000 && !mem_wr && rx_valid) m_dout = rx_data;
      else m_dout = 8'h00;
      if (m_fifo.size() > 0 && tx_ready) void'(m_fifo.pop_front());
      if (mem_wr && a == 18'h30000) begin
        if (m_fifo.size() < 8) m_fifo.push_back(mem_din);
        else m_ovf = 1'b1;
      end
      m_pop   = !mem_wr && a == 18'h30000 && rx_valid;
      m_end   = mem_wr && a == 18'h30004;
      m_bfull = m_fifo.size() >= 6;
    end else begin
      m_pop = 1'b0;
      m_end = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    bus(32'h0, 1'b0, 8'h00);
    model_reset();
    #2;
    checks++;
    if ({mem_dout, io_buffer_full, tx_valid, tx_data, rx_pop, program_end, io_overflow} !== 21'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {mem_dout, io_buffer_full, tx_valid, tx_data, rx_pop, program_end, io_overflow});
    end
    @(negedge clk);
    rst_in = 1'b0;
  endtask

  task automatic test_ram_roundtrip();
    bus(32'h00010, 1'b1, 8'hA5); step();
    bus(32'h00010, 1'b0, 8'h00); step();
    checks++;
    if (mem_dout !== 8'hA5) begin failures++; $display("FAIL ram_read got=%h want=a5", mem_dout); end
    bus(32'h00010, 1'b1, 8'h5A); step();
    checks++;
    if (mem_dout !== 8'hA5) begin failures++; $display("FAIL ram_read_before_write got=%h want=a5", mem_dout); end
    bus(32'hFFFC0010, 1'b0, 8'h00); step();
    checks++;
    if (mem_dout !== 8'h5A) begin failures++; $display("FAIL ram_high_bits_ignored got=%h want=5a", mem_dout); end
    bus(32'h20000, 1'b1, 8'h77); step();
    checks++;
    if (mem_dout !== 8'h00) begin failures++; $display("FAIL hole_write_dout got=%h want=00", mem_dout); end
    bus(32'h20000, 1'b0, 8'h00); step();
    checks++;
    if (mem_dout !== 8'h00) begin failures++; $display("FAIL hole_read got=%h want=00", mem_dout); end
  endtask

  task automatic fill_fifo(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      bus(32'h30000, 1'b1, first + 8'(i)); step();
    end
    bus(32'h00010, 1'b0, 8'h00);
  endtask

  task automatic test_fifo_fill();
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus(32'h30000, 1'b1, 8'(i)); step();
      checks++;
      if (io_buffer_full !== (i >= 6) || tx_valid !== 1'b1) begin
        failures++;
        $display("FAIL fifo_fill_push%0d full=%b valid=%b want full=%b valid=1", i, io_buffer_full, tx_valid, i >= 6);
      end
    end
    bus(32'h30000, 1'b1, 8'h09); step();
    checks++;
    if (io_overflow !== 1'b1 || io_buffer_full !== 1'b1) begin
      failures++; $display("FAIL fifo_overflow ovf=%b full=%b want 1 1", io_overflow, io_buffer_full);
    end
    bus(32'h00010, 1'b0, 8'h00);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (tx_data !== 8'(i) || tx_valid !== 1'b1) begin
        failures++; $display("FAIL fifo_drain%0d got=%h valid=%b want=%h", i, tx_data, tx_valid, 8'(i));
      end
      step();
    end
    checks++;
    if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin
      failures++; $display("FAIL fifo_empty valid=%b full=%b want 0 0", tx_valid, io_buffer_full);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    rst_in = 1'b1; model_reset(); @(negedge clk); rst_in = 1'b0;
    tx_ready = 1'b0;
    fill_fifo(8, 8'h01);
    tx_ready = 1'b1;
    bus(32'h30000, 1'b1, 8'h55); step();
    bus(32'h00010, 1'b0, 8'h00);
    checks++;
    if (io_overflow !== 1'b0 || io_buffer_full !== 1'b1 || tx_data !== 8'h02) begin
      failures++; $display("FAIL pushpop_full ovf=%b full=%b head=%h want 0 1 02", io_overflow, io_buffer_full, tx_data);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_data !== ((i == 7) ? 8'h55 : 8'(i + 2))) begin
        failures++; $display("FAIL pushpop_drain%0d got=%h want=%h", i, tx_data, (i == 7) ? 8'h55 : 8'(i + 2));
      end
      step();
    end
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL pushpop_empty valid=%b want=0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h3C;
    bus(32'h30000, 1'b0, 8'h00); step();
    checks++;
    if (mem_dout !== 8'h3C || rx_pop !== 1'b1) begin
      failures++; $display("FAIL rx_read dout=%h pop=%b want 3c 1", mem_dout, rx_pop);
    end
    bus(32'h00010, 1'b0, 8'h00); step();
    checks++;
    if (rx_pop !== 1'b0) begin failures++; $display("FAIL rx_pop_width pop=%b want=0", rx_pop); end
    rx_valid = 1'b0;
    bus(32'h30000, 1'b0, 8'h00); step();
    checks++;
    if (mem_dout !== 8'h00 || rx_pop !== 1'b0) begin
      failures++; $display("FAIL rx_empty dout=%h pop=%b want 00 0", mem_dout, rx_pop);
    end
  endtask

  task automatic test_end_stall();
    bus(32'h30004, 1'b1, 8'hFF); step();
    checks++;
    if (program_end !== 1'b1) begin failures++; $display("FAIL end_pulse got=%b want=1", program_end); end
    bus(32'h00010, 1'b0, 8'h00); step();
    checks++;
    if (program_end !== 1'b0 || mem_dout !== 8'h5A) begin
      failures++; $display("FAIL end_one_cycle end=%b dout=%h want 0 5a", program_end, mem_dout);
    end
    rdy_in = 1'b0;
    bus(32'h30004, 1'b1, 8'hFF); step();
    checks++;
    if (program_end !== 1'b0 || mem_dout !== 8'h5A) begin
      failures++; $display("FAIL stall_end end=%b dout=%h want 0 5a", program_end, mem_dout);
    end
    bus(32'h00010, 1'b1, 8'hEE); step();
    bus(32'h30000, 1'b1, 8'h77); step();
    checks++;
    if (tx_valid !== 1'b0 || mem_dout !== 8'h5A) begin
      failures++; $display("FAIL stall_push valid=%b dout=%h want 0 5a", tx_valid, mem_dout);
    end
    rdy_in = 1'b1;
    bus(32'h00010, 1'b0, 8'h00); step();
    checks++;
    if (mem_dout !== 8'h5A) begin failures++; $display("FAIL stall_ram got=%h want=5a", mem_dout); end
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    fill_fifo(9, 8'h10);
    tx_ready = 1'b1;
    repeat (3) step();
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || io_overflow !== 1'b1 || tx_data !== 8'h13) begin
      failures++; $display("FAIL pre_reset valid=%b ovf=%b head=%h want 1 1 13", tx_valid, io_overflow, tx_data);
    end
    #2 rst_in = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({tx_valid, io_buffer_full, io_overflow, tx_data, mem_dout} !== 19'h0) begin
      failures++; $display("FAIL async_reset valid=%b full=%b ovf=%b head=%h dout=%h want all 0",
                           tx_valid, io_buffer_full, io_overflow, tx_data, mem_dout);
    end
    @(negedge clk);
    rst_in = 1'b0;
    bus(32'h00010, 1'b0, 8'h00); step();
    checks++;
    if (mem_dout !== 8'h5A) begin failures++; $display("FAIL ram_after_reset got=%h want=5a", mem_dout); end
  endtask

  task automatic test_random();
    logic [17:0] pool [5];
    logic [31:0] hi;
    logic [17:0] a;
    logic [20:0] got, exp;
    pool = '{18'h00010, 18'h00100, 18'h1FFFF, 18'h0ABCD, 18'h10000};
    for (int i = 1; i < 5; i++) begin
      bus({14'h0, pool[i]}, 1'b1, 8'($urandom)); step();
    end
    for (int n = 0; n < 400; n++) begin
      int r;
      hi = $urandom();
      r  = $urandom_range(0, 9);
      if (r <= 3)      a = pool[$urandom_range(0, 4)];
      else if (r == 4) a = {2'b10, 16'($urandom)};
      else if (r <= 7) a = 18'h30000;
      else if (r == 8) a = 18'h30004;
      else             a = ($urandom_range(0, 1) != 0) ? 18'h30008 : 18'h3FFFF;
      bus({hi[31:18], a}, 1'($urandom), 8'($urandom));
      rdy_in   = ($urandom_range(0, 9) != 0);
      tx_ready = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      step();
      got = {mem_dout, io_buffer_full, tx_valid, tx_data, rx_pop, program_end, io_overflow};
      exp = {m_dout, m_bfull, m_fifo.size() != 0, (m_fifo.size() != 0) ? m_fifo[0] : 8'h00, m_pop, m_end, m_ovf};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL random_cycle%0d got=%h want=%h", n, got, exp);
      end
    end
    rdy_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ram_roundtrip();
    test_fifo_fill();
    test_back_to_back();
    test_rx();
    test_end_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Byte-wide memory responder on the far side of the memory controller's RAM port. It serves one-cycle registered reads and single-cycle writes to on-chip RAM. It decodes a memory-mapped IO window that pushes output bytes into a transmit FIFO, pops input bytes, and signals program end. It also generates `io_buffer_full`, which the controller samples before issuing IO-capable writes.

## Interface
- `ADDR_WIDTH`, 17: RAM size is 2^ADDR_WIDTH bytes, mapped at 0x00000–0x1FFFF.
- `FIFO_DEPTH_LOG`, 3: TX FIFO depth is 2^FIFO_DEPTH_LOG entries (8).
- `clk_in`  in  1  sole clock, rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `rdy_in`  in  1  global enable; when low, no state changes.
- `mem_a`  in  32  byte address from the controller; only [17:0] are decoded.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_din`  in  8  write data from the controller.
- `mem_dout`  out  8  registered read data to the controller.
- `io_buffer_full`  out  1  registered back-pressure to the controller.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts the head byte.
- `rx_data`  in  8  input byte.
- `rx_valid`  in  1  `rx_data` is available.
- `rx_pop`  out  1  one-cycle pulse that consumes `rx_data`.
- `program_end`  out  1  one-cycle pulse on a write to 0x30004.
- `io_overflow`  out  1  sticky flag set when a push finds the FIFO full.

## Operation
- Address decode on `mem_a[17:16]`:
  - 0x or 01 → RAM.
  - 10 → hole: reads return 0x00, writes are dropped.
  - 11 → IO.
- IO map:
  - Write 0x30000 → push `mem_din` into the TX FIFO.
  - Write 0x30004 → pulse `program_end`; data is ignored.
  - Read 0x30000 → return `rx_data` and pulse `rx_pop` if `rx_valid`, else return 0x00 with no pop.
  - All other IO addresses → read 0x00, writes ignored.
- RAM: synchronous single-port byte array with no reset of contents. A write at edge k is visible to a read of the same address sampled at edge k+1.
- `mem_dout` is registered every enabled cycle, including write cycles.
  - On a RAM write cycle it returns the old RAM byte (read-before-write).
  - On an IO or hole write cycle it returns 0x00.
- TX FIFO is a circular buffer with wrapping read/write pointers and a (FIFO_DEPTH_LOG+1)-bit count.
  - Push only when count < depth. Otherwise drop the byte and set `io_overflow`.
  - Pop when `tx_valid && tx_ready`.
  - Push and pop in the same cycle: both pointers advance, count unchanged. This applies when the FIFO is full too, because the pop frees the slot first.
- `io_buffer_full` = registered (count_next >= depth − 2). The two-entry margin covers a write already in flight when the controller sampled 0.
- `rdy_in` low freezes everything:
  - no RAM write, FIFO push or pop;
  - `mem_dout` held;
  - `rx_pop` and `program_end` forced 0.

## Timing
- Reset (async, immediate) values:
  - `mem_dout`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=0, `rx_pop`=0, `program_end`=0, `io_overflow`=0.
  - FIFO pointers and count = 0.
  - RAM contents are unaffected.
- Read latency: address sampled at edge k → `mem_dout` valid after edge k, held through edge k+1, where the controller samples it.
- `rx_pop` and `program_end` are registered. They are high for exactly the one cycle following the sampling edge.
- `tx_valid` and `tx_data` reflect the FIFO state after each edge; `tx_data` is the head entry.
- `io_buffer_full` updates on the same edge as the push or pop that changes count.
- Reset asserted mid-burst: the FIFO empties and all outputs clear immediately. Data not yet consumed is lost.

## Test plan
- RAM round trip:
  - Stimulus: write 0xA5 to 0x00010, then read 0x00010 on the next cycle.
  - Response: `mem_dout`=0xA5 one cycle after the read address is sampled. A read of 0x20000 returns 0x00.
- FIFO fill:
  - Stimulus: `tx_ready`=0, write bytes 0x01..0x08 to 0x30000, then write 0x09.
  - Response: `io_buffer_full` rises after the 6th push. Count reaches 8. The 9th byte is dropped and `io_overflow`=1. With `tx_ready`=1, bytes drain as 0x01..0x08 in order.
- Simultaneous push/pop:
  - Stimulus: FIFO at count 8, `tx_ready`=1, write 0x55.
  - Response: count stays 8 and 0x55 is stored. The pointer wraps correctly past index 7. No overflow.
- RX read:
  - Stimulus: `rx_valid`=1 with `rx_data`=0x3C, read 0x30000.
  - Response: `mem_dout`=0x3C and `rx_pop` high for one cycle. With `rx_valid`=0 the read returns 0x00 and there is no pop.
- End and stall:
  - Stimulus: write to 0x30004.
  - Response: `program_end` pulses for exactly one cycle.
  - Stimulus: repeat the write with `rdy_in`=0.
  - Response: no pulse, no RAM or FIFO change.
- Reset mid-operation:
  - Stimulus: assert `rst_in` asynchronously with the FIFO holding 5 bytes.
  - Response: `tx_valid`, `io_buffer_full` and `io_overflow` go to 0 before the next clock edge. RAM data written earlier still reads back correctly.
